reg_dump_reader: RTL and testbench

- Debug/trace reader on the register-file read side. On a start pulse it scans registers FIRST_REG..NUM_REGS-1 through one read port, in ascending order.
- Each value is emitted as a valid/ready stream beat carrying its index; the last beat is flagged.
- Sits beside the CPU datapath, shares a register-file read port (rd_addr/rd_data), and feeds a debug UART/trace FIFO.

---
 rtl/reg_dump_reader_pkg.sv | 15 +
 rtl/reg_dump_reader.sv | 198 +++++++++++++++++++
 tb/tb_reg_dump_reader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared CPU definitions for the register-dump reader and the register file.
package reg_dump_reader_pkg;

  // Register-file geometry, shared with the register file itself.
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  // Dump reader control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Register-file dump reader: scans FIRST_REG..NUM_REGS-1 through one read
// port and emits each value as a valid/ready beat tagged with its index.
// Optional build macro REG_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned ADDR_W    = REG_ADDR_W,
  parameter int unsigned DATA_W    = REG_DATA_W,
  parameter int unsigned FIRST_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_last,
  output logic              dout_is_chk
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO       = ADDR_W'(2);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] didx_q, didx_d;
  logic              last_q, last_d;
  logic              hs;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              is_chk_q, is_chk_d;
`endif

  assign hs = valid_q & dout_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decode; abort outranks a same-cycle handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    data_d    = data_q;
    didx_d    = didx_q;
    last_d    = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    chk_d     = chk_q;
    is_chk_d  = is_chk_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d     = FIRST_IDX;
          rd_addr_d = FIRST_IDX;
          busy_d    = 1'b1;
          state_d   = LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
          chk_d     = '0;
          is_chk_d  = 1'b0;
`endif
        end
      end

      LOAD: begin
        if (abort) begin
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          rd_addr_d = FIRST_IDX;
          state_d   = IDLE;
        end else begin
          // rd_addr_q == idx_q here, so rd_data is register idx_q.
          data_d    = rd_data;
          didx_d    = idx_q;
          valid_d   = 1'b1;
          rd_addr_d = idx_q + ONE;
          state_d   = SEND;
`ifdef REG_DUMP_CHECKSUM_EN
          last_d    = 1'b0;
          is_chk_d  = 1'b0;
`else
          last_d    = (idx_q == LAST_IDX);
`endif
        end
      end

      SEND: begin
        if (abort) begin
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          rd_addr_d = FIRST_IDX;
          state_d   = IDLE;
        end else if (hs) begin
          if (last_q) begin
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            rd_addr_d = FIRST_IDX;
            state_d   = IDLE;
          end
`ifdef REG_DUMP_CHECKSUM_EN
          else if (idx_q == LAST_IDX) begin
            // Final register beat accepted: follow with the checksum beat.
            chk_d    = chk_q ^ data_q;
            data_d   = chk_q ^ data_q;
            didx_d   = '0;
            last_d   = 1'b1;
            is_chk_d = 1'b1;
          end
`endif
          else begin
            // rd_addr_q == idx_q+1 is the prefetched next register.
            idx_d     = idx_q + ONE;
            data_d    = rd_data;
            didx_d    = idx_q + ONE;
            rd_addr_d = idx_q + TWO;
`ifdef REG_DUMP_CHECKSUM_EN
            chk_d     = chk_q ^ data_q;
            last_d    = 1'b0;
`else
            last_d    = ((idx_q + ONE) == LAST_IDX);
`endif
          end
        end
      end

      default: begin
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        rd_addr_d = FIRST_IDX;
        state_d   = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= FIRST_IDX;
      rd_addr_q <= FIRST_IDX;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      didx_q    <= '0;
      last_q    <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      chk_q     <= '0;
      is_chk_q  <= 1'b0;
`endif
    end else begin
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      didx_q    <= didx_d;
      last_q    <= last_d;
`ifdef REG_DUMP_CHECKSUM_EN
      chk_q     <= chk_d;
      is_chk_q  <= is_chk_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign rd_addr    = rd_addr_q;
  assign dout_valid = valid_q;
  assign dout_data  = data_q;
  assign dout_idx   = didx_q;
  assign dout_last  = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
  assign dout_is_chk = is_chk_q;
`else
  assign dout_is_chk = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader with a behavioural register file.
module tb_reg_dump_reader;

  localparam int NUM_REGS  = 32;
  localparam int FIRST_REG = 0;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;

  logic              clk = 1'b0;
  logic              rst, start, abort, dout_ready;
  logic              busy, dout_valid, dout_last, dout_is_chk;
  logic [ADDR_W-1:0] rd_addr, dout_idx;
  logic [DATA_W-1:0] rd_data, dout_data;

  logic [DATA_W-1:0] rf       [NUM_REGS];
  logic [DATA_W-1:0] model_rf [NUM_REGS];

  logic [DATA_W-1:0] q_data[$];
  logic [ADDR_W-1:0] q_idx[$];
  logic              q_last[$];
  logic              q_chk[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Combinational read; register 0 reads as zero.
  assign rd_data = (rd_addr == '0) ? '0 : rf[rd_addr];

  reg_dump_reader #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIRST_REG(FIRST_REG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_data(dout_data), .dout_idx(dout_idx),
    .dout_last(dout_last), .dout_is_chk(dout_is_chk)
  );

  task automatic preload();
    for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(i * 16);
    rf[26] = 32'h6c;
    rf[1]  = 32'h1;
    for (int i = 0; i < NUM_REGS; i++) model_rf[i] = rf[i];
  endtask

  // Expected beat list derived from the dump rules and model_rf.
  function automatic void build_expected();
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] v;
    x = '0;
    q_data.delete(); q_idx.delete(); q_last.delete(); q_chk.delete();
    for (int i = FIRST_REG; i < NUM_REGS; i++) begin
      v = (i == 0) ? '0 : model_rf[i];
      q_data.push_back(v);
      q_idx.push_back(ADDR_W'(i));
      q_chk.push_back(1'b0);
`ifdef REG_DUMP_CHECKSUM_EN
      q_last.push_back(1'b0);
`else
      q_last.push_back(i == NUM_REGS - 1);
`endif
      x = x ^ v;
    end
`ifdef REG_DUMP_CHECKSUM_EN
    q_data.push_back(x);
    q_idx.push_back('0);
    q_last.push_back(1'b1);
    q_chk.push_back(1'b1);
`endif
  endfunction

  // Run one dump from IDLE. mode: 0 ready=1, 1 toggle, 2 random.
  // stop_kind: 0 none, 1 abort at stop_idx, 2 reset at stop_idx,
  // 3 write r5=DEAD and pulse start at stop_idx.
  task automatic drive_dump(input string name, input int mode, input int stop_idx,
                            input int stop_kind, output int beats, output int vcyc);
    bit done, trig, hs, r, have_prev, prev_ready;
    logic [DATA_W-1:0] pd;
    logic [ADDR_W-1:0] pi;
    logic pl;
    beats = 0; vcyc = 0; done = 0; trig = 0; have_prev = 0; prev_ready = 0;
    pd = '0; pi = '0; pl = 1'b0;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s load_cycle busy=%b valid=%b required busy=1 valid=0", name, busy, dout_valid);
    end
    @(posedge clk); @(negedge clk);
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      checks++;
      if (dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s valid_gap cyc=%0d valid=%b required 1", name, cyc, dout_valid);
      end else begin
        if (have_prev && !prev_ready) begin
          checks++;
          if (dout_data !== pd || dout_idx !== pi || dout_last !== pl) begin
            errors++;
            $display("FAIL %s stall_stable data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                     name, dout_data, dout_idx, dout_last, pd, pi, pl);
          end
        end
        checks++;
        if (q_data.size() == 0) begin
          errors++;
          $display("FAIL %s extra_beat idx=%0d required none", name, dout_idx);
        end else if (dout_data !== q_data[0] || dout_idx !== q_idx[0] ||
                     dout_last !== q_last[0] || dout_is_chk !== q_chk[0]) begin
          errors++;
          $display("FAIL %s beat data=%h idx=%0d last=%b chk=%b required data=%h idx=%0d last=%b chk=%b",
                   name, dout_data, dout_idx, dout_last, dout_is_chk,
                   q_data[0], q_idx[0], q_last[0], q_chk[0]);
        end
      end
      case (mode)
        0: r = 1'b1;
        1: r = vcyc[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (dout_valid === 1'b1) vcyc++;
      if (stop_kind != 0 && !trig && dout_valid === 1'b1 && dout_is_chk === 1'b0 &&
          int'(dout_idx) == stop_idx) begin
        trig = 1;
        r = 1'b1;
        if (stop_kind == 1) abort = 1'b1;
        if (stop_kind == 2) rst = 1'b1;
        if (stop_kind == 3) begin rf[5] = 32'hDEAD; start = 1'b1; end
      end
      dout_ready = r;
      hs = (dout_valid === 1'b1) && r;
      have_prev = (dout_valid === 1'b1);
      prev_ready = r; pd = dout_data; pi = dout_idx; pl = dout_last;
      @(posedge clk); @(negedge clk);
      abort = 1'b0; start = 1'b0; rst = 1'b0;
      if (trig && (stop_kind == 1 || stop_kind == 2)) done = 1;
      else if (hs) begin
        beats++;
        if (q_data.size() != 0) begin
          void'(q_data.pop_front()); void'(q_idx.pop_front());
          void'(q_last.pop_front()); void'(q_chk.pop_front());
        end
        if (q_data.size() == 0) done = 1;
      end
    end
    dout_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout beats=%0d required completion", name, beats);
    end
    if (stop_kind == 0 || stop_kind == 3) begin
      checks++;
      if (busy !== 1'b0 || dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s end_idle busy=%b valid=%b required 0 0", name, busy, dout_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; dout_ready = 1'b0;
    preload();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0 || dout_data !== '0 || dout_idx !== '0 ||
        dout_last !== 1'b0 || dout_is_chk !== 1'b0 || rd_addr !== ADDR_W'(FIRST_REG)) begin
      errors++;
      $display("FAIL reset busy=%b valid=%b data=%h idx=%0d last=%b chk=%b addr=%0d required all 0, addr=%0d",
               busy, dout_valid, dout_data, dout_idx, dout_last, dout_is_chk, rd_addr, FIRST_REG);
    end
    rst = 1'b0;
    // abort alone in IDLE does nothing
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort busy=%b valid=%b required 0 0", busy, dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    int beats, vc;
    preload(); build_expected();
    drive_dump("back_to_back", 0, 0, 0, beats, vc);
    checks++;
    if (beats != q_beats_total() || vc != beats) begin
      errors++;
      $display("FAIL back_to_back count beats=%0d valid_cycles=%0d required %0d each",
               beats, vc, q_beats_total());
    end
  endtask

  function automatic int q_beats_total();
`ifdef REG_DUMP_CHECKSUM_EN
    return NUM_REGS - FIRST_REG + 1;
`else
    return NUM_REGS - FIRST_REG;
`endif
  endfunction

  task automatic test_ready_toggle();
    int beats, vc;
    preload(); build_expected();
    drive_dump("ready_toggle", 1, 0, 0, beats, vc);
    checks++;
    if (beats != q_beats_total() || vc != 2 * q_beats_total()) begin
      errors++;
      $display("FAIL ready_toggle count beats=%0d send_cycles=%0d required %0d %0d",
               beats, vc, q_beats_total(), 2 * q_beats_total());
    end
  endtask

  task automatic test_abort();
    int beats, vc;
    preload(); build_expected();
    drive_dump("abort", 0, 10, 1, beats, vc);
    checks++;
    if (beats != 10 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort beats=%0d busy=%b valid=%b required 10 0 0", beats, busy, dout_valid);
    end
    // restart from index 0 after abort
    build_expected();
    drive_dump("restart", 0, 0, 0, beats, vc);
    // start and abort together in IDLE: start wins, then abort in LOAD
    start = 1'b1; abort = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_wins busy=%b valid=%b required 1 0", busy, dout_valid);
    end
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_abort busy=%b valid=%b required 0 0", busy, dout_valid);
    end
  endtask

  task automatic test_coherency();
    int beats, vc;
    preload();
    model_rf[5] = 32'hDEAD;
    build_expected();
    drive_dump("coherency", 0, 3, 3, beats, vc);
    checks++;
    if (beats != q_beats_total()) begin
      errors++;
      $display("FAIL coherency count beats=%0d required %0d", beats, q_beats_total());
    end
  endtask

  task automatic test_reset_mid_dump();
    int beats, vc;
    preload(); build_expected();
    drive_dump("reset_mid", 0, 20, 2, beats, vc);
    checks++;
    if (beats != 20 || busy !== 1'b0 || dout_valid !== 1'b0 || dout_data !== '0 ||
        dout_idx !== '0 || dout_last !== 1'b0 || dout_is_chk !== 1'b0 ||
        rd_addr !== ADDR_W'(FIRST_REG)) begin
      errors++;
      $display("FAIL reset_mid beats=%0d busy=%b valid=%b data=%h idx=%0d last=%b addr=%0d required 20 and reset values",
               beats, busy, dout_valid, dout_data, dout_idx, dout_last, rd_addr);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0 || dout_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet valid=%b last=%b required 0 0", dout_valid, dout_last);
    end
  endtask

  task automatic test_random();
    int beats, vc;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] = $urandom;
        model_rf[i] = rf[i];
      end
      build_expected();
      drive_dump("random", 2, 0, 0, beats, vc);
      checks++;
      if (beats != q_beats_total()) begin
        errors++;
        $display("FAIL random count iter=%0d beats=%0d required %0d", t, beats, q_beats_total());
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ready_toggle();
    test_abort();
    test_coherency();
    test_reset_mid_dump();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
